// File: rtl/pdes_ctrl_pkg.sv
// Shared encodings for the PDES dispatch/control front end: FSM states,
// caep instruction codes, CSR addresses and exception bit positions.
package pdes_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_FINISHED = 2'd2,
      ST_ABORT    = 2'd3
   } state_t;

   localparam logic [4:0] INST_START = 5'd0;
   localparam logic [4:0] INST_ABORT = 5'd1;

   localparam logic [15:0] CSR_STATE      = 16'h0000;
   localparam logic [15:0] CSR_GVT        = 16'h0001;
   localparam logic [15:0] CSR_WDOG       = 16'h0002;
   localparam logic [15:0] CSR_RUNS       = 16'h000F;
   localparam logic [15:0] CSR_STATS_BASE = 16'h0010;

   localparam int EXC_UNIMPL  = 0;
   localparam int EXC_BAD_IDX = 1;
   localparam int EXC_TIMEOUT = 2;

endpackage

// File: rtl/pdes_watchdog.sv
// Saturating run-time watchdog: cleared at run start, counts while enabled,
// flags when the count reaches a non-zero limit (limit 0 disables it).
module pdes_watchdog #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         hit
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

   assign hit = (limit != '0) && (count == limit);

endmodule

// File: rtl/pdes_dispatch_ctrl.sv
// PDES dispatch/AEG/control front end: AEG file, caep decode, run FSM with
// watchdog, GVT/stats latching and CSR reads. Optional: PDES_CSR_STATS_EN.
//
// state    | meaning
// IDLE     | waiting for a start instruction
// RUNNING  | core released from reset (master AE), watchdog counting
// FINISHED | run completed, results latched; back to IDLE next cycle
// ABORT    | aborted by instruction or watchdog; back to IDLE next cycle
module pdes_dispatch_ctrl
   import pdes_ctrl_pkg::*;
#(
   parameter int NUM_AEG     = 16,
   parameter int AEG_IDX_W   = 4,
   parameter int RO_BASE     = 5,
   parameter int NUM_STATS   = 7,
   parameter int GVT_W       = 16,
   parameter int WDOG_W      = 32,
   parameter int WDOG_AEG    = 4,
   parameter int MASTER_AEID = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   disp_inst_vld,
   input  logic [4:0]             disp_inst,
   input  logic [17:0]            disp_aeg_idx,
   input  logic                   disp_aeg_rd,
   input  logic                   disp_aeg_wr,
   input  logic [63:0]            disp_aeg_wr_data,
   output logic [17:0]            disp_aeg_cnt,
   output logic [15:0]            disp_exception,
   output logic                   disp_idle,
   output logic                   disp_stall,
   output logic                   disp_rtn_data_vld,
   output logic [63:0]            disp_rtn_data,
   input  logic                   csr_rd_vld,
   input  logic [15:0]            csr_address,
   output logic                   csr_rd_ack,
   output logic [63:0]            csr_rd_data,
   input  logic [3:0]             i_aeid,
   output logic                   core_rst_n,
   input  logic                   core_done,
   input  logic [GVT_W-1:0]       core_gvt,
   input  logic [NUM_STATS*64-1:0] stats_in,
   output logic [NUM_AEG*64-1:0]  aeg_out
);

   state_t             state_q, state_d;
   logic               r_start, r_abort;
   logic               start_dec, abort_dec, unimpl_dec, idx_bad;
   logic               is_master, run_master, done_evt, timeout_evt;
   logic               wdog_clr, wdog_en, wdog_hit;
   logic [WDOG_W-1:0]  wdog_cnt;
   logic [GVT_W-1:0]   gvt_q;
   logic [2:0]         exc_q;
   logic [63:0]        csr_mux;
   logic [63:0]        aeg_view [NUM_AEG];

   assign start_dec  = disp_inst_vld && (disp_inst == INST_START);
   assign abort_dec  = disp_inst_vld && (disp_inst == INST_ABORT);
   assign unimpl_dec = disp_inst_vld && (disp_inst > INST_ABORT);
   assign idx_bad    = disp_aeg_idx >= 18'(NUM_AEG);
   assign is_master  = i_aeid == 4'(MASTER_AEID);

   assign disp_aeg_cnt   = 18'(NUM_AEG);
   assign disp_exception = {13'b0, exc_q};

   // Unified AEG view: writable regs, then GVT, then stats, then zero padding.
   for (genvar g = 0; g < NUM_AEG; g++) begin : g_aeg
      if (g < RO_BASE) begin : g_rw
         logic [63:0] q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else if (disp_aeg_wr && (disp_aeg_idx == 18'(g))) q <= disp_aeg_wr_data;
         end
         assign aeg_view[g] = q;
      end else if (g == RO_BASE) begin : g_gvt
         assign aeg_view[g] = 64'(gvt_q);
      end else if (g <= RO_BASE + NUM_STATS) begin : g_stat
         logic [63:0] q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else if (done_evt) q <= stats_in[64*(g-RO_BASE-1) +: 64];
         end
         assign aeg_view[g] = q;
      end else begin : g_pad
         assign aeg_view[g] = '0;
      end
      assign aeg_out[64*g +: 64] = aeg_view[g];
   end

   pdes_watchdog #(.W(WDOG_W)) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (wdog_clr),
      .en    (wdog_en),
      .limit (aeg_view[WDOG_AEG][WDOG_W-1:0]),
      .count (wdog_cnt),
      .hit   (wdog_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (r_start) state_d = ST_RUNNING;
         ST_RUNNING: begin
            if (!is_master || done_evt)  state_d = ST_FINISHED;
            else if (r_abort)            state_d = ST_ABORT;
            else if (timeout_evt)        state_d = ST_ABORT;
         end
         ST_FINISHED: state_d = ST_IDLE;
         ST_ABORT:    state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      run_master  = (state_q == ST_RUNNING) && is_master;
      core_rst_n  = run_master;
      disp_idle   = (state_q == ST_IDLE) && !r_start;
      disp_stall  = (state_q != ST_IDLE) || start_dec || r_start;
      wdog_clr    = (state_q == ST_IDLE) && r_start;
      done_evt    = run_master && core_done;
      timeout_evt = run_master && !core_done && !r_abort && wdog_hit;
      wdog_en     = run_master && !core_done && !r_abort && !wdog_hit;
   end

`ifdef PDES_CSR_STATS_EN
   logic [31:0] run_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_cnt <= '0;
      else if ((state_q == ST_RUNNING) && (state_d == ST_FINISHED)) run_cnt <= run_cnt + 32'd1;
   end
`endif

   always_comb begin
      csr_mux = '0;
      case (csr_address)
         CSR_STATE: csr_mux = {62'b0, state_q};
         CSR_GVT:   csr_mux = 64'(gvt_q);
         CSR_WDOG:  csr_mux = 64'(wdog_cnt);
         default:   csr_mux = '0;
      endcase
`ifdef PDES_CSR_STATS_EN
      if (csr_address == CSR_RUNS) csr_mux = 64'(run_cnt);
      if ((csr_address >= CSR_STATS_BASE) && (csr_address < CSR_STATS_BASE + 16'(NUM_STATS)))
         csr_mux = aeg_view[AEG_IDX_W'(csr_address - CSR_STATS_BASE) + AEG_IDX_W'(RO_BASE + 1)];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start           <= 1'b0;
         r_abort           <= 1'b0;
         exc_q             <= '0;
         gvt_q             <= '0;
         disp_rtn_data_vld <= 1'b0;
         disp_rtn_data     <= '0;
         csr_rd_ack        <= 1'b0;
         csr_rd_data       <= '0;
      end else begin
         r_start                <= start_dec;
         r_abort                <= abort_dec;
         exc_q[EXC_UNIMPL]      <= unimpl_dec;
         exc_q[EXC_BAD_IDX]     <= (disp_aeg_rd || disp_aeg_wr) && idx_bad;
         exc_q[EXC_TIMEOUT]     <= timeout_evt;
         if (done_evt) gvt_q    <= core_gvt;
         disp_rtn_data_vld      <= disp_aeg_rd;
         disp_rtn_data          <= (disp_aeg_rd && !idx_bad) ? aeg_view[disp_aeg_idx[AEG_IDX_W-1:0]] : '0;
         csr_rd_ack             <= csr_rd_vld;
         csr_rd_data            <= csr_rd_vld ? csr_mux : '0;
      end
   end

endmodule

// File: tb/tb_pdes_dispatch_ctrl.sv
// Directed bench for pdes_dispatch_ctrl: AEG access, run FSM, watchdog, abort.
module tb_pdes_dispatch_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          disp_inst_vld;
   logic [4:0]    disp_inst;
   logic [17:0]   disp_aeg_idx;
   logic          disp_aeg_rd, disp_aeg_wr;
   logic [63:0]   disp_aeg_wr_data;
   logic [17:0]   disp_aeg_cnt;
   logic [15:0]   disp_exception;
   logic          disp_idle, disp_stall, disp_rtn_data_vld;
   logic [63:0]   disp_rtn_data;
   logic          csr_rd_vld;
   logic [15:0]   csr_address;
   logic          csr_rd_ack;
   logic [63:0]   csr_rd_data;
   logic [3:0]    i_aeid;
   logic          core_rst_n, core_done;
   logic [15:0]   core_gvt;
   logic [447:0]  stats_in;
   logic [1023:0] aeg_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pdes_dispatch_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst),
      .disp_aeg_idx(disp_aeg_idx), .disp_aeg_rd(disp_aeg_rd), .disp_aeg_wr(disp_aeg_wr),
      .disp_aeg_wr_data(disp_aeg_wr_data), .disp_aeg_cnt(disp_aeg_cnt),
      .disp_exception(disp_exception), .disp_idle(disp_idle), .disp_stall(disp_stall),
      .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
      .csr_rd_vld(csr_rd_vld), .csr_address(csr_address), .csr_rd_ack(csr_rd_ack),
      .csr_rd_data(csr_rd_data), .i_aeid(i_aeid), .core_rst_n(core_rst_n),
      .core_done(core_done), .core_gvt(core_gvt), .stats_in(stats_in), .aeg_out(aeg_out)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] d);
      disp_aeg_wr = 1'b1; disp_aeg_idx = idx; disp_aeg_wr_data = d;
      step;
      disp_aeg_wr = 1'b0;
   endtask

   task automatic aeg_rd(input logic [17:0] idx);
      disp_aeg_rd = 1'b1; disp_aeg_idx = idx;
      step;
      disp_aeg_rd = 1'b0;
   endtask

   task automatic issue(input logic [4:0] code);
      disp_inst_vld = 1'b1; disp_inst = code;
      step;
      disp_inst_vld = 1'b0;
   endtask

   task automatic csr_rd(input logic [15:0] a, output logic [63:0] d, output logic ack);
      csr_rd_vld = 1'b1; csr_address = a;
      step;
      d = csr_rd_data; ack = csr_rd_ack;
      csr_rd_vld = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      n_checks++; if (disp_idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", disp_idle); else n_pass++;
      n_checks++; if (disp_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", disp_stall); else n_pass++;
      n_checks++; if (core_rst_n !== 1'b0) $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); else n_pass++;
      n_checks++; if (disp_exception !== 16'h0) $display("FAIL rst_exc: got %h want 0", disp_exception); else n_pass++;
      n_checks++; if (disp_aeg_cnt !== 18'd16) $display("FAIL aeg_cnt: got %0d want 16", disp_aeg_cnt); else n_pass++;
      n_checks++; if (aeg_out !== '0) $display("FAIL rst_aeg_out: got nonzero want 0"); else n_pass++;
      rst_n = 1'b1;
      step;
   endtask

   task automatic test_aeg_rw;
      aeg_wr(18'd3, 64'hABCD);
      aeg_wr(18'd5, 64'h1);
      n_checks++; if (disp_exception !== 16'h0) $display("FAIL ro_wr_exc: got %h want 0", disp_exception); else n_pass++;
      aeg_rd(18'd3);
      n_checks++; if (disp_rtn_data_vld !== 1'b1) $display("FAIL rd_vld: got %b want 1", disp_rtn_data_vld); else n_pass++;
      n_checks++; if (disp_rtn_data !== 64'hABCD) $display("FAIL rd_aeg3: got %h want abcd", disp_rtn_data); else n_pass++;
      aeg_rd(18'd5);
      n_checks++; if (disp_rtn_data !== 64'h0) $display("FAIL rd_aeg5: got %h want 0", disp_rtn_data); else n_pass++;
      aeg_rd(18'd16);
      n_checks++; if (disp_rtn_data !== 64'h0) $display("FAIL rd_idx16: got %h want 0", disp_rtn_data); else n_pass++;
      n_checks++; if (disp_exception !== 16'h2) $display("FAIL rd_bad_exc: got %h want 2", disp_exception); else n_pass++;
      step;
      n_checks++; if (disp_exception !== 16'h0) $display("FAIL bad_exc_pulse: got %h want 0", disp_exception); else n_pass++;
      n_checks++; if (disp_rtn_data_vld !== 1'b0) $display("FAIL rd_vld_drop: got %b want 0", disp_rtn_data_vld); else n_pass++;
      disp_aeg_rd = 1'b1; disp_aeg_wr = 1'b1; disp_aeg_idx = 18'd3; disp_aeg_wr_data = 64'h5555;
      step;
      disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0;
      n_checks++; if (disp_rtn_data !== 64'hABCD) $display("FAIL rd_wr_same: got %h want abcd", disp_rtn_data); else n_pass++;
      aeg_rd(18'd3);
      n_checks++; if (disp_rtn_data !== 64'h5555) $display("FAIL rd_after_wr: got %h want 5555", disp_rtn_data); else n_pass++;
      n_checks++; if (aeg_out[64*3 +: 64] !== 64'h5555) $display("FAIL aeg_out3: got %h want 5555", aeg_out[64*3 +: 64]); else n_pass++;
      aeg_wr(18'd20, 64'h9);
      n_checks++; if (disp_exception !== 16'h2) $display("FAIL wr_bad_exc: got %h want 2", disp_exception); else n_pass++;
   endtask

   task automatic test_master_run;
      logic [63:0] d;
      logic        ack;
      i_aeid = 4'd0;
      disp_inst_vld = 1'b1; disp_inst = 5'd0;
      #1;
      n_checks++; if (disp_stall !== 1'b1) $display("FAIL stall_decode: got %b want 1", disp_stall); else n_pass++;
      n_checks++; if (disp_idle !== 1'b1) $display("FAIL idle_decode: got %b want 1", disp_idle); else n_pass++;
      step;
      disp_inst_vld = 1'b0;
      n_checks++; if (disp_idle !== 1'b0) $display("FAIL idle_rstart: got %b want 0", disp_idle); else n_pass++;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL st_rstart: got %0d want 0", dut.state_q); else n_pass++;
      step;
      n_checks++; if (dut.state_q !== 2'd1) $display("FAIL st_running: got %0d want 1", dut.state_q); else n_pass++;
      n_checks++; if (core_rst_n !== 1'b1) $display("FAIL core_rst_run: got %b want 1", core_rst_n); else n_pass++;
      core_done = 1'b1; core_gvt = 16'h1234; stats_in[63:0] = 64'd100; stats_in[64*6 +: 64] = 64'd7;
      step;
      core_done = 1'b0;
      n_checks++; if (dut.state_q !== 2'd2) $display("FAIL st_finished: got %0d want 2", dut.state_q); else n_pass++;
      n_checks++; if (disp_stall !== 1'b1) $display("FAIL stall_fin: got %b want 1", disp_stall); else n_pass++;
      n_checks++; if (core_rst_n !== 1'b0) $display("FAIL core_rst_fin: got %b want 0", core_rst_n); else n_pass++;
      step;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL st_idle_after: got %0d want 0", dut.state_q); else n_pass++;
      n_checks++; if (disp_stall !== 1'b0) $display("FAIL stall_idle: got %b want 0", disp_stall); else n_pass++;
      aeg_rd(18'd5);
      n_checks++; if (disp_rtn_data !== 64'h1234) $display("FAIL gvt_aeg5: got %h want 1234", disp_rtn_data); else n_pass++;
      aeg_rd(18'd6);
      n_checks++; if (disp_rtn_data !== 64'd100) $display("FAIL stat0_aeg6: got %0d want 100", disp_rtn_data); else n_pass++;
      aeg_rd(18'd12);
      n_checks++; if (disp_rtn_data !== 64'd7) $display("FAIL stat6_aeg12: got %0d want 7", disp_rtn_data); else n_pass++;
      csr_rd(16'h1, d, ack);
      n_checks++; if (ack !== 1'b1) $display("FAIL csr_ack: got %b want 1", ack); else n_pass++;
      n_checks++; if (d !== 64'h1234) $display("FAIL csr_gvt: got %h want 1234", d); else n_pass++;
      csr_rd(16'h7, d, ack);
      n_checks++; if (d !== 64'h0) $display("FAIL csr_other: got %h want 0", d); else n_pass++;
   endtask

   task automatic test_watchdog;
      logic [63:0] d;
      logic        ack;
      int          run_cycles;
      aeg_wr(18'd4, 64'd10);
      issue(5'd0);
      step;
      run_cycles = 0;
      for (int k = 0; k < 40 && dut.state_q == 2'd1; k++) begin
         run_cycles++;
         step;
      end
      n_checks++; if (run_cycles !== 11) $display("FAIL wdog_run_cycles: got %0d want 11", run_cycles); else n_pass++;
      n_checks++; if (dut.state_q !== 2'd3) $display("FAIL wdog_abort_st: got %0d want 3", dut.state_q); else n_pass++;
      n_checks++; if (disp_exception !== 16'h4) $display("FAIL wdog_exc: got %h want 4", disp_exception); else n_pass++;
      n_checks++; if (core_rst_n !== 1'b0) $display("FAIL wdog_core_rst: got %b want 0", core_rst_n); else n_pass++;
      step;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL wdog_idle: got %0d want 0", dut.state_q); else n_pass++;
      n_checks++; if (disp_exception !== 16'h0) $display("FAIL wdog_exc_pulse: got %h want 0", disp_exception); else n_pass++;
      csr_rd(16'h2, d, ack);
      n_checks++; if (d !== 64'd10) $display("FAIL csr_wdog: got %0d want 10", d); else n_pass++;
      core_gvt = 16'h0042;
      issue(5'd0);
      step;
      for (int k = 0; k < 10; k++) step;
      n_checks++; if (dut.state_q !== 2'd1) $display("FAIL wdog_edge_run: got %0d want 1", dut.state_q); else n_pass++;
      core_done = 1'b1;
      step;
      core_done = 1'b0;
      n_checks++; if (dut.state_q !== 2'd2) $display("FAIL done_beats_wdog: got %0d want 2", dut.state_q); else n_pass++;
      n_checks++; if (disp_exception !== 16'h0) $display("FAIL done_no_exc: got %h want 0", disp_exception); else n_pass++;
      step;
      csr_rd(16'h1, d, ack);
      n_checks++; if (d !== 64'h42) $display("FAIL csr_gvt2: got %h want 42", d); else n_pass++;
   endtask

   task automatic test_non_master;
      logic [63:0] d;
      logic        ack;
      i_aeid = 4'd1;
      core_gvt = 16'h9999; core_done = 1'b1;
      step;
      core_done = 1'b0;
      issue(5'd0);
      step;
      n_checks++; if (dut.state_q !== 2'd1) $display("FAIL nm_running: got %0d want 1", dut.state_q); else n_pass++;
      n_checks++; if (core_rst_n !== 1'b0) $display("FAIL nm_core_rst: got %b want 0", core_rst_n); else n_pass++;
      step;
      n_checks++; if (dut.state_q !== 2'd2) $display("FAIL nm_finished: got %0d want 2", dut.state_q); else n_pass++;
      step;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL nm_idle: got %0d want 0", dut.state_q); else n_pass++;
      csr_rd(16'h1, d, ack);
      n_checks++; if (d !== 64'h42) $display("FAIL idle_done_ignored: got %h want 42", d); else n_pass++;
      i_aeid = 4'd0;
   endtask

   task automatic test_abort;
      logic [63:0] d;
      logic        ack;
      aeg_wr(18'd4, 64'd0);
      issue(5'd0);
      step;
      step;
      csr_rd(16'h0, d, ack);
      n_checks++; if (d !== 64'd1) $display("FAIL csr_state_run: got %0d want 1", d); else n_pass++;
      issue(5'd1);
      n_checks++; if (dut.state_q !== 2'd1) $display("FAIL abort_rabort: got %0d want 1", dut.state_q); else n_pass++;
      step;
      n_checks++; if (dut.state_q !== 2'd3) $display("FAIL abort_st: got %0d want 3", dut.state_q); else n_pass++;
      n_checks++; if (disp_exception !== 16'h0) $display("FAIL abort_no_timeout: got %h want 0", disp_exception); else n_pass++;
      n_checks++; if (core_rst_n !== 1'b0) $display("FAIL abort_core_rst: got %b want 0", core_rst_n); else n_pass++;
      step;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL abort_idle: got %0d want 0", dut.state_q); else n_pass++;
      issue(5'd1);
      step;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL abort_in_idle: got %0d want 0", dut.state_q); else n_pass++;
      issue(5'd7);
      n_checks++; if (disp_exception !== 16'h1) $display("FAIL unimpl_exc: got %h want 1", disp_exception); else n_pass++;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL unimpl_state: got %0d want 0", dut.state_q); else n_pass++;
      step;
      n_checks++; if (disp_exception !== 16'h0) $display("FAIL unimpl_pulse: got %h want 0", disp_exception); else n_pass++;
   endtask

   task automatic test_reset_mid_run;
      logic [63:0] d;
      logic        ack;
      aeg_wr(18'd2, 64'h77);
      issue(5'd0);
      step;
      for (int k = 0; k < 4; k++) step;
      n_checks++; if (core_rst_n !== 1'b1) $display("FAIL mid_run_core: got %b want 1", core_rst_n); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (dut.state_q !== 2'd0) $display("FAIL mrst_state: got %0d want 0", dut.state_q); else n_pass++;
      n_checks++; if (core_rst_n !== 1'b0) $display("FAIL mrst_core: got %b want 0", core_rst_n); else n_pass++;
      n_checks++; if (disp_idle !== 1'b1) $display("FAIL mrst_idle: got %b want 1", disp_idle); else n_pass++;
      n_checks++; if (aeg_out !== '0) $display("FAIL mrst_aeg_out: got nonzero want 0"); else n_pass++;
      #3 rst_n = 1'b1;
      step;
      csr_rd(16'h1, d, ack);
      n_checks++; if (d !== 64'h0) $display("FAIL mrst_gvt: got %h want 0", d); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      disp_inst_vld = 1'b0; disp_inst = '0; disp_aeg_idx = '0;
      disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0; disp_aeg_wr_data = '0;
      csr_rd_vld = 1'b0; csr_address = '0; i_aeid = '0;
      core_done = 1'b0; core_gvt = '0; stats_in = '0;
      test_reset;
      test_aeg_rw;
      test_master_run;
      test_watchdog;
      test_non_master;
      test_abort;
      test_reset_mid_run;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pdes_dispatch_ctrl.md
Name: pdes_dispatch_ctrl

Overview:
Parametrised dispatch/AEG/control front end for the PDES personality. It holds the AEG register file and decodes caep instructions (start/abort). It runs the simulation control FSM with a watchdog, drives the PHOLD core's start/reset, latches GVT and a configurable number of statistics counters, and serves CSR reads. It sits between the Convey dispatch/CSR interfaces and the phold core inside the personality top level.

Parameters:
NUM_AEG, 16, number of AEG registers (power of 2, >= RO_BASE+1+NUM_STATS)
AEG_IDX_W, 4, log2(NUM_AEG)
RO_BASE, 5, first read-only AEG index (GVT); stats at RO_BASE+1 .. RO_BASE+NUM_STATS
NUM_STATS, 7, number of 64-bit statistics inputs
GVT_W, 16, core GVT width (zero-extended to 64)
WDOG_W, 32, watchdog counter width
WDOG_AEG, 4, AEG index holding watchdog limit (bits WDOG_W-1:0; 0 = disabled)
MASTER_AEID, 0, AE id that runs the core

Ports:
clk  in  1  personality clock
rst_n  in  1  asynchronous active-low reset
disp_inst_vld  in  1  instruction valid
disp_inst  in  5  instruction code: 0 = start, 1 = abort
disp_aeg_idx  in  18  AEG index
disp_aeg_rd  in  1  AEG read strobe
disp_aeg_wr  in  1  AEG write strobe
disp_aeg_wr_data  in  64  AEG write data
disp_aeg_cnt  out  18  constant NUM_AEG
disp_exception  out  16  [0] unimpl inst, [1] bad AEG idx, [2] watchdog timeout, others 0
disp_idle  out  1  idle indication
disp_stall  out  1  dispatch stall
disp_rtn_data_vld  out  1  AEG read data valid
disp_rtn_data  out  64  AEG read data
csr_rd_vld  in  1  CSR read strobe
csr_address  in  16  CSR address
csr_rd_ack  out  1  CSR read ack
csr_rd_data  out  64  CSR read data
i_aeid  in  4  this AE's id
core_rst_n  out  1  core active-low reset (released only while running)
core_done  in  1  core completion pulse (rtn_vld)
core_gvt  in  GVT_W  core final GVT
stats_in  in  NUM_STATS*64  flattened stats, index i at [64*i +: 64]
aeg_out  out  NUM_AEG*64  flattened AEG contents to core

Behaviour:
- Reset (rst_n low, async): all AEGs, GVT, stats, watchdog, pipeline flops = 0; state IDLE; all registered outputs 0; disp_idle = 1, disp_stall = 0.
- AEG write: idx < RO_BASE → register updated next edge. idx in [RO_BASE, NUM_AEG) → write ignored, no exception. idx >= NUM_AEG → ignored, exception[1].
- AEG read: disp_rtn_data_vld one cycle after disp_aeg_rd. Data is the pre-edge value (read and write of the same index in the same cycle returns the old value). Out-of-range index returns 0 and raises exception[1]. Unused RO indices read 0.
- exception[0]: registered one-cycle pulse for disp_inst_vld with code > 1. exception[1]: registered pulse for rd|wr with bad idx. exception[2]: one-cycle pulse on the RUNNING→ABORT transition caused by timeout.
- Start (code 0) is registered (r_start). Abort (code 1) is registered (r_abort).
- FSM IDLE/RUNNING/FINISHED/ABORT:
  - IDLE→RUNNING on r_start; watchdog cleared.
  - RUNNING, non-master AE → FINISHED next cycle.
  - RUNNING, master AE: core_done → FINISHED; else r_abort → ABORT; else (limit != 0 and wdog == limit) → ABORT with timeout. Otherwise wdog increments (saturating at all-ones).
  - FINISHED→IDLE; ABORT→IDLE unconditionally.
  - Start while not IDLE is ignored. Abort in IDLE is ignored.
- Priority for simultaneous events: core_done > abort > timeout.
- core_done in RUNNING (master only): GVT AEG ← zero-extended core_gvt; stats AEGs ← stats_in. core_done outside RUNNING is ignored. Latched values persist until the next core_done; they are not cleared on start.
- core_rst_n = (state==RUNNING) && (i_aeid==MASTER_AEID), driven from registered state. Entering ABORT reasserts core reset immediately.
- disp_idle = (state==IDLE) && !r_start. disp_stall = (state!=IDLE) || start_decoded || r_start.
- CSR (one-cycle latency, ack = registered csr_rd_vld): 0x0 = {62'b0, state}; 0x1 = GVT; 0x2 = {watchdog zero-extended}; others 0.

Optional Feature:
PDES_CSR_STATS_EN: when defined, CSR 0x10+i (i < NUM_STATS) returns latched stat i, and 0x0F returns a 32-bit count of completed runs (FINISHED entries, wraps). When undefined, these addresses read 0 and the run counter is not built.

Decomposition:
pdes_ctrl_pkg: FSM state encoding, instruction codes, CSR address constants, exception bit positions. One natural sub-module: pdes_watchdog (counter, clear, enable, limit compare, saturate).

Test Plan:
- Reset mid-RUNNING (rst_n low at cycle 5 of run) → state IDLE, core_rst_n 0, AEGs 0, disp_idle 1 in the same cycle.
- Write AEG3=0xABCD, then write AEG5=0x1 and read both → rtn 0xABCD and 0, one cycle after rd; read idx 16 → rtn 0, exception[1] pulse.
- Master: start, core_done with core_gvt=0x1234, stats_in[0]=100 → FSM RUNNING→FINISHED→IDLE; AEG5=0x1234, AEG6=100; disp_stall high from decode through FINISHED.
- AEG4=10, start, no core_done → ABORT after 10 RUNNING cycles, exception[2] pulses once, core_rst_n drops; core_done coincident with the limit → FINISHED, no exception.
- Non-master (i_aeid=1): start → RUNNING one cycle → FINISHED; core_rst_n stays 0.
- Abort instruction during RUNNING → ABORT next cycle, then IDLE; inst code 7 → exception[0] pulse, state unchanged.
